ofdm_subcarrier_demapper: RTL and testbench

Streaming OFDM subcarrier demapper placed directly downstream of the FFT stage (FFT-shifted, 64-point) in the Schmidl-Cox receive chain. It consumes one FFT output symbol per packet, discards guard, DC and pilot bins according to a programmable keep-mask, and emits only the data subcarriers as a packet. It also flags malformed symbol lengths and counts symbols.

---
 rtl/ofdm_subcarrier_demapper.sv | 141 ++++++++++++++
 tb/tb_ofdm_subcarrier_demapper.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ofdm_subcarrier_demapper.sv
// Streams FFT-shifted bins through a programmable keep-mask, emitting data subcarriers only.
// Optional OFDM_DEMAP_BIN_INDEX_EN adds o_tuser carrying the source bin index of each beat.
module ofdm_subcarrier_demapper #(
  parameter int FFT_SIZE = 64,
  parameter int WIDTH = 32,
  parameter logic [FFT_SIZE-1:0] DEFAULT_MASK = 64'h07DF_FF7E_FDFF_F7C0,
  localparam int IDX_W = $clog2(FFT_SIZE)
) (
  input  logic             ce_clk,
  input  logic             ce_rst,
  input  logic [WIDTH-1:0] i_tdata,
  input  logic             i_tlast,
  input  logic             i_tvalid,
  output logic             i_tready,
  output logic [WIDTH-1:0] o_tdata,
  output logic             o_tlast,
  output logic             o_tvalid,
`ifdef OFDM_DEMAP_BIN_INDEX_EN
  output logic [IDX_W-1:0] o_tuser,
`endif
  input  logic             o_tready,
  input  logic             cfg_wr,
  input  logic [IDX_W-1:0] cfg_addr,
  input  logic             cfg_data,
  output logic             err_short,
  output logic             err_long,
  output logic [15:0]      sym_count
);

  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(FFT_SIZE - 1);
  localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

  // Highest set bit of a mask; an all-zero mask yields 0, which is harmless
  // because bin 0 is then never kept.
  function automatic logic [IDX_W-1:0] highest_bit(input logic [FFT_SIZE-1:0] m);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int k = 0; k < FFT_SIZE; k++) begin
      if (m[k]) r = k[IDX_W-1:0];
    end
    return r;
  endfunction

  localparam logic [IDX_W-1:0] DEFAULT_LAST = highest_bit(DEFAULT_MASK);

  logic [IDX_W-1:0]    idx;
  logic [FFT_SIZE-1:0] shadow_mask;
  logic [FFT_SIZE-1:0] active_mask;
  logic [IDX_W-1:0]    last_keep;

  logic                hs;
  logic                at_first;
  logic                at_end;
  logic [FFT_SIZE-1:0] shadow_byp;
  logic [FFT_SIZE-1:0] cur_mask;
  logic [IDX_W-1:0]    byp_last;
  logic [IDX_W-1:0]    cur_last;
  logic                keep;
  logic                short_end;
  logic                emit;
  logic                tlast_nxt;

  assign i_tready = !o_tvalid || o_tready;
  assign hs       = i_tvalid && i_tready;
  assign at_first = (idx == '0);
  assign at_end   = (idx == IDX_MAX);

  // A write landing with bin 0 must reach the mask copied for this symbol.
  always_comb begin
    shadow_byp = shadow_mask;
    if (cfg_wr) shadow_byp[cfg_addr] = cfg_data;
  end

  assign byp_last = highest_bit(shadow_byp);
  assign cur_mask = at_first ? shadow_byp : active_mask;
  assign cur_last = at_first ? byp_last : last_keep;

  assign keep      = cur_mask[idx];
  assign short_end = i_tlast && !at_end;
  assign emit      = keep || short_end;
  assign tlast_nxt = short_end || (keep && (idx == cur_last));

  always_ff @(posedge ce_clk or negedge ce_rst) begin
    if (!ce_rst) begin
      shadow_mask <= DEFAULT_MASK;
      active_mask <= DEFAULT_MASK;
      last_keep   <= DEFAULT_LAST;
    end else begin
      shadow_mask <= shadow_byp;
      if (hs && at_first) begin
        active_mask <= shadow_byp;
        last_keep   <= byp_last;
      end
    end
  end

  always_ff @(posedge ce_clk or negedge ce_rst) begin
    if (!ce_rst) begin
      idx       <= '0;
      err_short <= 1'b0;
      err_long  <= 1'b0;
      sym_count <= 16'd0;
    end else begin
      err_short <= hs && short_end;
      err_long  <= hs && at_end && !i_tlast;
      if (hs) begin
        if (i_tlast || at_end) begin
          idx       <= '0;
          sym_count <= sym_count + 16'd1;
        end else begin
          idx <= idx + IDX_ONE;
        end
      end
    end
  end

  always_ff @(posedge ce_clk or negedge ce_rst) begin
    if (!ce_rst) begin
      o_tvalid <= 1'b0;
      o_tdata  <= '0;
      o_tlast  <= 1'b0;
    end else if (i_tready) begin
      o_tvalid <= hs && emit;
      if (hs && emit) begin
        o_tdata <= i_tdata;
        o_tlast <= tlast_nxt;
      end
    end
  end

`ifdef OFDM_DEMAP_BIN_INDEX_EN
  always_ff @(posedge ce_clk or negedge ce_rst) begin
    if (!ce_rst) begin
      o_tuser <= '0;
    end else if (hs && emit && i_tready) begin
      o_tuser <= idx;
    end
  end
`endif

endmodule

// File: tb/tb_ofdm_subcarrier_demapper.sv
// Scoreboard bench for ofdm_subcarrier_demapper: driver pushes expected beats,
// a negedge monitor pops and compares every transferred output beat.
module tb_ofdm_subcarrier_demapper;

  localparam logic [63:0] DEF_MASK = 64'h07DF_FF7E_FDFF_F7C0;

  logic        ce_clk = 1'b0;
  logic        ce_rst = 1'b0;
  logic [31:0] i_tdata = '0;
  logic        i_tlast = 1'b0;
  logic        i_tvalid = 1'b0;
  logic        i_tready;
  logic [31:0] o_tdata;
  logic        o_tlast;
  logic        o_tvalid;
  logic        o_tready = 1'b1;
  logic        cfg_wr = 1'b0;
  logic [5:0]  cfg_addr = '0;
  logic        cfg_data = 1'b0;
  logic        err_short;
  logic        err_long;
  logic [15:0] sym_count;

  ofdm_subcarrier_demapper dut (
    .ce_clk(ce_clk), .ce_rst(ce_rst),
    .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(i_tready),
    .o_tdata(o_tdata), .o_tlast(o_tlast), .o_tvalid(o_tvalid), .o_tready(o_tready),
    .cfg_wr(cfg_wr), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .err_short(err_short), .err_long(err_long), .sym_count(sym_count)
  );

  always #5 ce_clk = ~ce_clk;

  int errors = 0;
  int checks = 0;
  logic [32:0] exp_q[$];
  int n_out = 0, cnt_short = 0, cnt_long = 0;
  int exp_short = 0, exp_long = 0;
  int exp_sym = 0;
  bit rand_rdy = 0;

  logic [63:0] m_shadow = DEF_MASK;
  logic [63:0] m_active = DEF_MASK;
  int m_last = 58;
  int m_idx = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int top_bit(input logic [63:0] m);
    for (int k = 63; k >= 0; k--) if (m[k]) return k;
    return 0;
  endfunction

  task automatic model_accept(input int data, input bit last, input bit cw, input int cbin, input bit cval);
    bit kp, sh;
    if (cw) m_shadow[cbin] = cval;
    if (m_idx == 0) begin
      m_active = m_shadow;
      m_last   = top_bit(m_active);
    end
    kp = m_active[m_idx];
    sh = last && (m_idx != 63);
    if (kp || sh) exp_q.push_back({sh || (kp && m_idx == m_last), data[31:0]});
    if (sh) exp_short++;
    if (!last && m_idx == 63) exp_long++;
    if (last || m_idx == 63) begin
      exp_sym++;
      m_idx = 0;
    end else begin
      m_idx++;
    end
  endtask

  // Monitor: a beat visible with valid&ready at negedge transfers at the next posedge.
  bit          prev_stall = 0;
  logic [32:0] prev_beat = '0;
  always @(negedge ce_clk) begin
    logic [32:0] e;
    if (ce_rst) begin
      if (err_short) cnt_short++;
      if (err_long) cnt_long++;
      if (prev_stall) begin
        checks++;
        if (!o_tvalid || {o_tlast, o_tdata} != prev_beat) begin
          errors++;
          $display("FAIL stall_hold: got v=%0d last=%0d data=%0d expected v=1 last=%0d data=%0d",
                   o_tvalid, o_tlast, o_tdata, prev_beat[32], prev_beat[31:0]);
        end
      end
      prev_stall = o_tvalid && !o_tready;
      prev_beat  = {o_tlast, o_tdata};
      if (o_tvalid && o_tready) begin
        n_out++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat: got last=%0d data=%0d expected no beat", o_tlast, o_tdata);
        end else begin
          e = exp_q.pop_front();
          if ({o_tlast, o_tdata} != e) begin
            errors++;
            $display("FAIL out_beat: got last=%0d data=%0d expected last=%0d data=%0d",
                     o_tlast, o_tdata, e[32], e[31:0]);
          end
        end
      end
    end else begin
      prev_stall = 0;
    end
  end

  always @(posedge ce_clk) begin
    #1 o_tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic send_symbol(input int n, input int last_at, input int cfg_at,
                             input int cbin, input bit cval);
    bit hs;
    int tries;
    for (int j = 0; j < n; j++) begin
      i_tvalid = 1'b1;
      i_tdata  = j;
      i_tlast  = (j == last_at);
      cfg_wr   = (j == cfg_at);
      cfg_addr = cbin[5:0];
      cfg_data = cval;
      tries = 0;
      hs = 0;
      while (!hs) begin
        @(negedge ce_clk);
        hs = i_tready;
        if (hs) model_accept(j, j == last_at, j == cfg_at, cbin, cval);
        @(posedge ce_clk);
        #1;
        tries++;
        if (!hs && tries > 1000) begin
          errors++;
          $display("FAIL input_timeout: got no handshake expected one within 1000 cycles");
          hs = 1;
        end
      end
      cfg_wr = 1'b0;
    end
    i_tvalid = 1'b0;
    i_tlast  = 1'b0;
  endtask

  task automatic cfg_write(input int bin, input bit val);
    cfg_wr = 1'b1; cfg_addr = bin[5:0]; cfg_data = val;
    @(posedge ce_clk); #1;
    cfg_wr = 1'b0;
    m_shadow[bin] = val;
  endtask

  task automatic drain(input string name);
    int t = 0;
    while (exp_q.size() != 0 && t < 500) begin
      @(posedge ce_clk); #1;
      t++;
    end
    chk({name, "_drain_left"}, exp_q.size(), 0);
    repeat (3) @(posedge ce_clk);
    #1;
  endtask

  task automatic run_case(input string name, input int n, input int last_at, input int cfg_at,
                          input int cbin, input bit cval, input int exp_beats);
    int n0 = n_out;
    send_symbol(n, last_at, cfg_at, cbin, cval);
    drain(name);
    chk({name, "_beats"}, n_out - n0, exp_beats);
    chk({name, "_sym_count"}, int'(sym_count), exp_sym);
  endtask

  initial begin
    repeat (3) @(posedge ce_clk);
    #1;
    chk("rst_o_tvalid", o_tvalid, 0);
    chk("rst_o_tlast", o_tlast, 0);
    chk("rst_o_tdata", o_tdata, 0);
    chk("rst_i_tready", i_tready, 1);
    chk("rst_err_short", err_short, 0);
    chk("rst_err_long", err_long, 0);
    chk("rst_sym_count", sym_count, 0);
    @(negedge ce_clk) ce_rst = 1'b1;
    @(posedge ce_clk); #1;

    run_case("default", 64, 63, -1, 0, 0, 48);
    chk("default_sym_is_1", int'(sym_count), 1);

    rand_rdy = 1;
    run_case("stalled", 64, 63, -1, 0, 0, 48);
    rand_rdy = 0;

    run_case("cfg_prev_sym", 64, 63, 30, 60, 1, 48);
    run_case("cfg_applied", 64, 63, -1, 0, 0, 49);
    cfg_write(60, 0);
    run_case("cfg_bin0_bypass", 64, 63, 0, 60, 1, 49);
    cfg_write(60, 0);
    run_case("mask_restored", 64, 63, -1, 0, 0, 48);

    run_case("short", 21, 20, -1, 0, 0, 14);
    chk("short_err_pulses", cnt_short, 1);
    run_case("after_short", 64, 63, -1, 0, 0, 48);

    rand_rdy = 1;
    run_case("long", 70, -1, -1, 0, 0, 48);
    rand_rdy = 0;
    chk("long_err_pulses", cnt_long, 1);
    chk("long_no_short", cnt_short, 1);
    run_case("long_tail", 58, 57, -1, 0, 0, 48);

    cfg_write(20, 0);
    send_symbol(30, -1, -1, 0, 0);
    ce_rst = 1'b0;
    i_tvalid = 1'b0;
    repeat (2) @(posedge ce_clk);
    #1;
    chk("midrst_o_tvalid", o_tvalid, 0);
    chk("midrst_o_tdata", o_tdata, 0);
    chk("midrst_i_tready", i_tready, 1);
    chk("midrst_sym_count", sym_count, 0);
    exp_q.delete();
    m_shadow = DEF_MASK; m_active = DEF_MASK; m_last = 58; m_idx = 0; exp_sym = 0;
    @(negedge ce_clk) ce_rst = 1'b1;
    @(posedge ce_clk); #1;
    run_case("post_rst", 64, 63, -1, 0, 0, 48);
    chk("post_rst_sym_is_1", int'(sym_count), 1);

    chk("total_err_short", cnt_short, exp_short);
    chk("total_err_long", cnt_long, exp_long);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
